ab_multi_frame_er_ctrl: RTL

- Sequencer for the Alice/Bob error-reconciliation (ER) pair across many frames.
- Generates a debounced start; issues one start_er pulse per frame, shared by the A-side and B-side single-frame ER engines.
- Ping-pongs the sifted-key half (sifted_key_addr_index) each frame and accumulates leaked-info and error-count statistics.
- Applies a configurable verification-fail policy and a per-frame watchdog.

---
 rtl/er_ctrl_pkg.sv | 10 +
 rtl/sat_acc.sv | 23 ++
 rtl/ab_multi_frame_er_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/er_ctrl_pkg.sv
// er_ctrl_pkg: shared state encoding, default widths and fail-policy constants
package er_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_DONE, S_ERR} state_t;
  localparam int DEF_FRAME_ROUND_WIDTH = 16;
  localparam int DEF_LEAK_W = 16;
  localparam int DEF_ERR_W = 16;
  localparam int DEF_ACC_W = 32;
  localparam bit FAIL_CONTINUE = 1'b0;
  localparam bit FAIL_ABORT_RUN = 1'b1;
endpackage

// File: rtl/sat_acc.sv
// sat_acc: accumulator that sticks at all-ones instead of wrapping
module sat_acc #(
  parameter int ACC_W = 32,
  parameter int IN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc
);
  logic [ACC_W:0] sum;
  logic [ACC_W-1:0] acc_q, acc_d;
  always_comb begin
    sum = {1'b0, acc_q} + (ACC_W+1)'(din);
    acc_d = clr ? '0 : !en ? acc_q : sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/ab_multi_frame_er_ctrl.sv
// ab_multi_frame_er_ctrl: multi-frame sequencer for the Alice/Bob ER engine pair
module ab_multi_frame_er_ctrl
  import er_ctrl_pkg::*;
#(
  parameter int START_DELAY = 128,
  parameter int FRAME_ROUND_WIDTH = DEF_FRAME_ROUND_WIDTH,
  parameter int LEAK_W = DEF_LEAK_W,
  parameter int ERR_W = DEF_ERR_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 2**24,
  parameter bit FAIL_ABORT = FAIL_CONTINUE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_switch,
  input  logic                         stop_req,
  input  logic [FRAME_ROUND_WIDTH-1:0] num_frames,
  output logic                         start_er,
  output logic [FRAME_ROUND_WIDTH-1:0] frame_round,
  output logic                         sifted_key_addr_index,
  input  logic                         A_finish_error_reconciliation,
  input  logic                         B_finish_error_reconciliation,
  input  logic                         A_error_verification_fail,
  input  logic                         B_error_verification_fail,
  input  logic [LEAK_W-1:0]            A_er_leaked_info,
  input  logic [ERR_W-1:0]             A_er_error_count,
  input  logic                         A_er_parameter_valid,
  output logic [ACC_W-1:0]             total_leaked_info,
  output logic [ACC_W-1:0]             total_error_count,
  output logic [FRAME_ROUND_WIDTH-1:0] frames_ok,
  output logic [FRAME_ROUND_WIDTH-1:0] frames_failed,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  output logic                         abort_err
);
  localparam int FW = FRAME_ROUND_WIDTH;
  localparam int AW = $clog2(START_DELAY) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [FW-1:0] FR_ONE = FW'(1);

  state_t state_q, state_d;
  logic [AW-1:0] arm_cnt_q, arm_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic [FW-1:0] nf_q, nf_d, frame_round_q, frame_round_d, frames_ok_q, frames_ok_d, frames_failed_q, frames_failed_d;
  logic [LEAK_W-1:0] leak_q, leak_d, leak_c;
  logic [ERR_W-1:0] err_q, err_d, err_c;
  logic idx_q, idx_d, fin_a_q, fin_a_d, fin_b_q, fin_b_d, fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic pv_q, pv_d, stop_q, stop_d, start_er_q, start_er_d, busy_q, busy_d, done_q, done_d;
  logic timeout_err_q, timeout_err_d, abort_err_q, abort_err_d;
  logic pv, fail, complete, arm, last;

  // Current-cycle events are merged with the latches so the completing edge sees them
  always_comb begin
    pv = pv_q | A_er_parameter_valid;
    leak_c = pv_q ? leak_q : A_er_leaked_info;
    err_c = pv_q ? err_q : A_er_error_count;
    fail = fail_a_q | fail_b_q | A_error_verification_fail | B_error_verification_fail;
    complete = state_q == S_WAIT && (fin_a_q | A_finish_error_reconciliation) && (fin_b_q | B_finish_error_reconciliation);
    arm = state_q == S_IDLE && start_switch && arm_cnt_q == AW'(START_DELAY - 1);
    last = frame_round_q + FR_ONE == nf_q;
    state_d = state_q;
    arm_cnt_d = arm_cnt_q;
    gap_cnt_d = gap_cnt_q;
    wd_cnt_d = wd_cnt_q;
    nf_d = nf_q;
    frame_round_d = frame_round_q;
    frames_ok_d = frames_ok_q;
    frames_failed_d = frames_failed_q;
    leak_d = leak_q;
    err_d = err_q;
    idx_d = idx_q;
    fin_a_d = fin_a_q;
    fin_b_d = fin_b_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    pv_d = pv_q;
    stop_d = busy_q ? stop_q | stop_req : stop_q;
    start_er_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    timeout_err_d = timeout_err_q;
    abort_err_d = abort_err_q;
    case (state_q)
      S_IDLE: begin
        arm_cnt_d = start_switch ? arm_cnt_q + AW'(1) : '0;
        if (arm) begin
          arm_cnt_d = '0;
          nf_d = num_frames;
          frame_round_d = '0;
          idx_d = 1'b0;
          frames_ok_d = '0;
          frames_failed_d = '0;
          timeout_err_d = 1'b0;
          abort_err_d = 1'b0;
          stop_d = 1'b0;
          state_d = num_frames == '0 ? S_DONE : S_LAUNCH;
          done_d = num_frames == '0;
          start_er_d = num_frames != '0;
          busy_d = num_frames != '0;
        end
      end
      S_LAUNCH: begin
        {fin_a_d, fin_b_d, fail_a_d, fail_b_d, pv_d} = '0;
        wd_cnt_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        fin_a_d = fin_a_q | A_finish_error_reconciliation;
        fin_b_d = fin_b_q | B_finish_error_reconciliation;
        fail_a_d = fail_a_q | A_error_verification_fail;
        fail_b_d = fail_b_q | B_error_verification_fail;
        pv_d = pv;
        leak_d = leak_c;
        err_d = err_c;
        wd_cnt_d = wd_cnt_q + WW'(1);
        if (complete) begin
          frames_ok_d = fail ? frames_ok_q : frames_ok_q + FR_ONE;
          frames_failed_d = fail ? frames_failed_q + FR_ONE : frames_failed_q;
          if (fail && FAIL_ABORT) begin
            abort_err_d = 1'b1;
            busy_d = 1'b0;
            state_d = S_ERR;
          end else if (last || stop_q || stop_req) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = S_DONE;
          end else begin
            idx_d = ~idx_q;
            frame_round_d = frame_round_q + FR_ONE;
            gap_cnt_d = '0;
            state_d = S_GAP;
          end
        end else if (wd_cnt_q == WW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          busy_d = 1'b0;
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        start_er_d = gap_cnt_q == GW'(GAP_CYCLES);
        state_d = gap_cnt_q == GW'(GAP_CYCLES) ? S_LAUNCH : S_GAP;
      end
      default: begin
        arm_cnt_d = '0;
        state_d = start_switch ? state_q : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      arm_cnt_q <= '0;
      gap_cnt_q <= '0;
      wd_cnt_q <= '0;
      nf_q <= '0;
      frame_round_q <= '0;
      frames_ok_q <= '0;
      frames_failed_q <= '0;
      leak_q <= '0;
      err_q <= '0;
      idx_q <= 1'b0;
      fin_a_q <= 1'b0;
      fin_b_q <= 1'b0;
      fail_a_q <= 1'b0;
      fail_b_q <= 1'b0;
      pv_q <= 1'b0;
      stop_q <= 1'b0;
      start_er_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      timeout_err_q <= 1'b0;
      abort_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_cnt_q <= arm_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      wd_cnt_q <= wd_cnt_d;
      nf_q <= nf_d;
      frame_round_q <= frame_round_d;
      frames_ok_q <= frames_ok_d;
      frames_failed_q <= frames_failed_d;
      leak_q <= leak_d;
      err_q <= err_d;
      idx_q <= idx_d;
      fin_a_q <= fin_a_d;
      fin_b_q <= fin_b_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      pv_q <= pv_d;
      stop_q <= stop_d;
      start_er_q <= start_er_d;
      busy_q <= busy_d;
      done_q <= done_d;
      timeout_err_q <= timeout_err_d;
      abort_err_q <= abort_err_d;
    end

  sat_acc #(.ACC_W(ACC_W), .IN_W(LEAK_W)) u_leak_acc (
    .clk(clk), .rst_n(rst_n), .clr(arm), .en(complete & pv), .din(leak_c), .acc(total_leaked_info)
  );
  sat_acc #(.ACC_W(ACC_W), .IN_W(ERR_W)) u_err_acc (
    .clk(clk), .rst_n(rst_n), .clr(arm), .en(complete & pv & ~fail), .din(err_c), .acc(total_error_count)
  );

  assign start_er = start_er_q;
  assign frame_round = frame_round_q;
  assign sifted_key_addr_index = idx_q;
  assign frames_ok = frames_ok_q;
  assign frames_failed = frames_failed_q;
  assign busy = busy_q;
  assign done = done_q;
  assign timeout_err = timeout_err_q;
  assign abort_err = abort_err_q;
endmodule
